// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the register-file write arbiter: default widths and the
// producer port indices used to index request/grant vectors.
package regfile_write_arbiter_pkg;
  localparam int RF_DATA_WIDTH = 8;
  localparam int RF_ADDR_WIDTH = 2;
  localparam int RF_NREGS      = 2**RF_ADDR_WIDTH;
  localparam int PORT_ALU      = 0;
  localparam int PORT_MEM      = 1;
endpackage

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant from two request bits, with the
// pointer moving to the non-granted port after every grant.
module rr_arb2
  import regfile_write_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic rr_q, rr_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = rr_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
    rr_d = rr_q;
    if (gnt_o[PORT_ALU])      rr_d = 1'(PORT_MEM);
    else if (gnt_o[PORT_MEM]) rr_d = 1'(PORT_ALU);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_q <= 1'(PORT_ALU);
    else       rr_q <= rr_d;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between the ALU and memory-load producers.
// Optional WRARB_CONFLICT_CNT_EN adds a saturating contention counter output.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  localparam int NREGS     = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  aluValid,
  output logic                  aluReady,
  input  logic [ADDR_WIDTH-1:0] aluAddr,
  input  logic [DATA_WIDTH-1:0] aluData,
  input  logic                  memValid,
  output logic                  memReady,
  input  logic [ADDR_WIDTH-1:0] memAddr,
  input  logic [DATA_WIDTH-1:0] memData,
  output logic                  regWrite,
  output logic [ADDR_WIDTH-1:0] wrAddress,
  output logic [DATA_WIDTH-1:0] dataIn,
  output logic [NREGS-1:0]      pending,
  output logic                  busy
`ifdef WRARB_CONFLICT_CNT_EN
  ,output logic [7:0]           conflictCount
`endif
);

  logic [1:0]            hv_q, hv_d;
  logic [ADDR_WIDTH-1:0] ha_q [2];
  logic [ADDR_WIDTH-1:0] ha_d [2];
  logic [DATA_WIDTH-1:0] hd_q [2];
  logic [DATA_WIDTH-1:0] hd_d [2];
  logic [ADDR_WIDTH-1:0] in_addr [2];
  logic [DATA_WIDTH-1:0] in_data [2];
  logic [1:0]            in_valid, ready, accept, gnt;

  logic                  regWrite_q, regWrite_d;
  logic [ADDR_WIDTH-1:0] wrAddress_q, wrAddress_d;
  logic [DATA_WIDTH-1:0] dataIn_q, dataIn_d;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req_i (hv_q),
    .gnt_o (gnt)
  );

  // A granted slot may be refilled on the same edge it drains.
  always_comb begin
    in_valid[PORT_ALU] = aluValid;
    in_valid[PORT_MEM] = memValid;
    in_addr[PORT_ALU]  = aluAddr;
    in_addr[PORT_MEM]  = memAddr;
    in_data[PORT_ALU]  = aluData;
    in_data[PORT_MEM]  = memData;
    ready  = ~hv_q | gnt;
    accept = in_valid & ready;
    for (int p = 0; p < 2; p++) begin
      hv_d[p] = hv_q[p];
      ha_d[p] = ha_q[p];
      hd_d[p] = hd_q[p];
      if (gnt[p]) hv_d[p] = 1'b0;
      if (accept[p]) begin
        hv_d[p] = 1'b1;
        ha_d[p] = in_addr[p];
        hd_d[p] = in_data[p];
      end
    end
  end

  always_comb begin
    regWrite_d  = |gnt;
    wrAddress_d = wrAddress_q;
    dataIn_d    = dataIn_q;
    if (gnt[PORT_MEM]) begin
      wrAddress_d = ha_q[PORT_MEM];
      dataIn_d    = hd_q[PORT_MEM];
    end else if (gnt[PORT_ALU]) begin
      wrAddress_d = ha_q[PORT_ALU];
      dataIn_d    = hd_q[PORT_ALU];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hv_q        <= 2'b00;
      ha_q        <= '{default: '0};
      hd_q        <= '{default: '0};
      regWrite_q  <= 1'b0;
      wrAddress_q <= '0;
      dataIn_q    <= '0;
    end else begin
      hv_q        <= hv_d;
      ha_q        <= ha_d;
      hd_q        <= hd_d;
      regWrite_q  <= regWrite_d;
      wrAddress_q <= wrAddress_d;
      dataIn_q    <= dataIn_d;
    end
  end

  // Hazard mask covers both waiting writes and the one being written this cycle.
  always_comb begin
    pending = '0;
    for (int r = 0; r < NREGS; r++) begin
      for (int p = 0; p < 2; p++)
        if (hv_q[p] && ha_q[p] == ADDR_WIDTH'(r)) pending[r] = 1'b1;
      if (regWrite_q && wrAddress_q == ADDR_WIDTH'(r)) pending[r] = 1'b1;
    end
  end

  assign aluReady  = ready[PORT_ALU];
  assign memReady  = ready[PORT_MEM];
  assign regWrite  = regWrite_q;
  assign wrAddress = wrAddress_q;
  assign dataIn    = dataIn_q;
  assign busy      = |hv_q | regWrite_q;

`ifdef WRARB_CONFLICT_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (&hv_q && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

  assign conflictCount = cnt_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; the contention-counter scenario is
// included when WRARB_CONFLICT_CNT_EN is defined.
module tb_regfile_write_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       aluValid, aluReady, memValid, memReady;
  logic [1:0] aluAddr, memAddr, wrAddress;
  logic [7:0] aluData, memData, dataIn;
  logic       regWrite, busy;
  logic [3:0] pending;
`ifdef WRARB_CONFLICT_CNT_EN
  logic [7:0] conflictCount;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  regfile_write_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .aluValid  (aluValid),
    .aluReady  (aluReady),
    .aluAddr   (aluAddr),
    .aluData   (aluData),
    .memValid  (memValid),
    .memReady  (memReady),
    .memAddr   (memAddr),
    .memData   (memData),
    .regWrite  (regWrite),
    .wrAddress (wrAddress),
    .dataIn    (dataIn),
    .pending   (pending),
    .busy      (busy)
`ifdef WRARB_CONFLICT_CNT_EN
    ,.conflictCount (conflictCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    aluValid = 1'b1; aluAddr = 2'd2; aluData = 8'd25;
    memValid = 1'b0; memAddr = 2'd0; memData = 8'd0;

    // Reset held with a request pending: nothing accepted or written
    tick(); tick();
    chk("rst_regWrite", 32'(regWrite), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wrAddress", 32'(wrAddress), 32'd0);
    chk("rst_dataIn", 32'(dataIn), 32'd0);
    chk("rst_aluReady", 32'(aluReady), 32'd1);
    reset = 1'b0;
    tick();
    chk("t1_acc_pending", 32'(pending), 32'b0100);
    chk("t1_acc_regWrite", 32'(regWrite), 32'd0);
    chk("t1_acc_busy", 32'(busy), 32'd1);
    aluValid = 1'b0;
    tick();
    chk("t1_wr_regWrite", 32'(regWrite), 32'd1);
    chk("t1_wr_addr", 32'(wrAddress), 32'd2);
    chk("t1_wr_data", 32'(dataIn), 32'd25);
    chk("t1_wr_pending", 32'(pending), 32'b0100);
    tick();
    chk("t1_idle_regWrite", 32'(regWrite), 32'd0);
    chk("t1_idle_pending", 32'(pending), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_idle_dataHold", 32'(dataIn), 32'd25);

    // Simultaneous requests from reset: ALU first, mem next cycle
    do_reset();
    aluValid = 1'b1; aluAddr = 2'd1; aluData = 8'd100;
    memValid = 1'b1; memAddr = 2'd3; memData = 8'd45;
    tick();
    chk("t2_acc_pending", 32'(pending), 32'b1010);
    aluValid = 1'b0; memValid = 1'b0;
    tick();
    chk("t2_w1_regWrite", 32'(regWrite), 32'd1);
    chk("t2_w1_addr", 32'(wrAddress), 32'd1);
    chk("t2_w1_data", 32'(dataIn), 32'd100);
    chk("t2_w1_pending", 32'(pending), 32'b1010);
    tick();
    chk("t2_w2_regWrite", 32'(regWrite), 32'd1);
    chk("t2_w2_addr", 32'(wrAddress), 32'd3);
    chk("t2_w2_data", 32'(dataIn), 32'd45);
    chk("t2_w2_pending", 32'(pending), 32'b1000);
    tick();
    chk("t2_end_regWrite", 32'(regWrite), 32'd0);
    chk("t2_end_pending", 32'(pending), 32'd0);

    // Same address from both ports, three writes each: strict alternation
    do_reset();
    aluValid = 1'b1; aluAddr = 2'd0; aluData = 8'd45;
    memValid = 1'b1; memAddr = 2'd0; memData = 8'd99;
    tick();
    chk("t3_e1_regWrite", 32'(regWrite), 32'd0);
    chk("t3_e1_aluReady", 32'(aluReady), 32'd1);
    chk("t3_e1_memReady", 32'(memReady), 32'd0);
    tick();
    chk("t3_e2_data", 32'(dataIn), 32'd45);
    chk("t3_e2_aluReady", 32'(aluReady), 32'd0);
    chk("t3_e2_memReady", 32'(memReady), 32'd1);
    tick();
    chk("t3_e3_data", 32'(dataIn), 32'd99);
    chk("t3_e3_aluReady", 32'(aluReady), 32'd1);
    tick();
    chk("t3_e4_data", 32'(dataIn), 32'd45);
    aluValid = 1'b0;
    tick();
    chk("t3_e5_data", 32'(dataIn), 32'd99);
    memValid = 1'b0;
    tick();
    chk("t3_e6_data", 32'(dataIn), 32'd45);
    chk("t3_e6_addr", 32'(wrAddress), 32'd0);
    tick();
    chk("t3_e7_regWrite", 32'(regWrite), 32'd1);
    chk("t3_e7_data", 32'(dataIn), 32'd99);
    tick();
    chk("t3_e8_regWrite", 32'(regWrite), 32'd0);
    chk("t3_final_data", 32'(dataIn), 32'd99);

    // Uncontested ALU stream: one write per cycle
    aluValid = 1'b1; aluAddr = 2'd0; aluData = 8'd10;
    chk("t4_ready0", 32'(aluReady), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t4_rw%0d", i), 32'(regWrite), (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) chk($sformatf("t4_data%0d", i), 32'(dataIn), 32'(10 + i - 1));
      chk($sformatf("t4_ready%0d", i + 1), 32'(aluReady), 32'd1);
      if (i < 3) begin
        aluAddr = 2'(i + 1);
        aluData = 8'(11 + i);
      end else begin
        aluValid = 1'b0;
      end
    end
    tick();
    chk("t4_last_rw", 32'(regWrite), 32'd1);
    chk("t4_last_data", 32'(dataIn), 32'd13);
    chk("t4_last_addr", 32'(wrAddress), 32'd3);
    tick();
    chk("t4_end_rw", 32'(regWrite), 32'd0);

    // Reset while both holding registers are full
    do_reset();
    aluValid = 1'b1; aluAddr = 2'd1; aluData = 8'hAA;
    memValid = 1'b1; memAddr = 2'd2; memData = 8'hBB;
    tick();
    chk("t5_full_busy", 32'(busy), 32'd1);
    chk("t5_full_pending", 32'(pending), 32'b0110);
    #1 reset = 1'b1;
    #1;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_pending", 32'(pending), 32'd0);
    chk("t5_rst_aluReady", 32'(aluReady), 32'd1);
    chk("t5_rst_memReady", 32'(memReady), 32'd1);
    chk("t5_rst_regWrite", 32'(regWrite), 32'd0);
    tick(); tick();
    chk("t5_rst_noacc", 32'(busy), 32'd0);
    aluValid = 1'b0; memValid = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t5_post_rw%0d", i), 32'(regWrite), 32'd0);
      chk($sformatf("t5_post_data%0d", i), 32'(dataIn), 32'd0);
    end

`ifdef WRARB_CONFLICT_CNT_EN
    do_reset();
    chk("t6_cnt_rst", 32'(conflictCount), 32'd0);
    aluValid = 1'b1; aluAddr = 2'd0; aluData = 8'd1;
    memValid = 1'b1; memAddr = 2'd0; memData = 8'd2;
    repeat (300) tick();
    chk("t6_cnt_sat", 32'(conflictCount), 32'd255);
    aluValid = 1'b0; memValid = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 4×8-bit main register file between two producers: the ALU writeback path (port 0) and the memory load path (port 1). Each producer hands off one write at a time over a valid/ready handshake into a one-entry holding register. A two-way round-robin arbiter drains the holding registers into registered `regWrite`/address/data outputs that connect directly to the register file. A per-register pending mask is exported so the issue logic can stall on read-after-write hazards.

## Interface
Parameters:
- `DATA_WIDTH`, 8, register data width
- `ADDR_WIDTH`, 2, register address width; `NREGS = 2**ADDR_WIDTH`

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `aluValid`  in  1  port 0 write request
- `aluReady`  out  1  port 0 can accept (combinational)
- `aluAddr`  in  ADDR_WIDTH  port 0 destination register
- `aluData`  in  DATA_WIDTH  port 0 write data
- `memValid` / `memReady` / `memAddr` / `memData`: port 1, same meaning as port 0
- `regWrite`  out  1  register-file write enable (registered)
- `wrAddress`  out  ADDR_WIDTH  register-file write address (registered)
- `dataIn`  out  DATA_WIDTH  register-file write data (registered)
- `pending`  out  NREGS  bit r = 1 while any held or in-flight write targets register r
- `busy`  out  1  OR of both holding-valid flags and `regWrite`

## Operation
- Holding register per port: `hv_i`, `ha_i`, `hd_i`. Loads on the edge where `valid_i && ready_i`.
- `ready_i = ~hv_i | grant_i`. Refill in the same cycle as drain is allowed.
- Grant (combinational, from `hv` and the round-robin pointer `rr`):
  - neither held: no grant
  - one held: grant it
  - both held: grant port `rr`
- After any grant, `rr` points to the non-granted port.
- Grant edge: `regWrite <= 1`, `wrAddress <= ha_g`, `dataIn <= hd_g`, and `hv_g` clears unless reloaded on the same edge.
- No grant: `regWrite <= 0`. `wrAddress` and `dataIn` hold their values.
- Same-address writes from both ports are both performed, in grant order. The later write wins. Neither is merged or dropped.
- `pending[r]`: OR over `(hv_i && ha_i == r)` and `(regWrite && wrAddress == r)`.
- Reset values: `hv_0 = hv_1 = 0`, `rr = 0` (ALU first), `regWrite = 0`, `wrAddress = 0`, `dataIn = 0`, `pending = 0`, `busy = 0`.
- Reset asserted mid-operation: held and in-flight requests are discarded and no write is issued. Ready outputs go to 1 as soon as reset is asserted, but acceptance is blocked while reset is high.

## Timing
- Handshake edge N (request accepted) → grant edge N+1 (if uncontested) → register file writes on edge N+2. Latency is 2 clocks.
- Under contention the losing port is delayed by exactly 1 cycle.
- Sustained throughput is one write per cycle across both ports, and one per cycle per port when uncontested.
- `pending[r]` rises in cycle N+1 and falls after edge N+2.
- Producers must hold `valid`, `addr` and `data` stable until ready. `valid` must not depend combinationally on `ready`.

## Configuration
- `WRARB_CONFLICT_CNT_EN` defined:
  - adds output `conflictCount` (8-bit), which increments on each grant edge where both `hv` were set
  - the counter saturates at 255 and resets to 0
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package/header: `DATA_WIDTH`, `ADDR_WIDTH`, `NREGS`, and port index constants `PORT_ALU = 0`, `PORT_MEM = 1`.
- Sub-module `rr_arb2`: two request bits plus `rr` state, producing a one-hot grant. It owns the pointer update and reuses the same async reset.
- The top level contains the holding registers, the output registers and the pending decode.

## Test plan
- Reset with `aluValid = 1` held → `regWrite = 0`, `pending = 0`, no acceptance until reset drops. Then ALU write addr 2, data 25 → `regWrite` high one cycle later with `wrAddress = 2`, `dataIn = 25`.
- Simultaneous ALU (addr 1, data 100) and mem (addr 3, data 45) from reset → ALU written first, mem written next cycle. `pending = 4'b1010` then `4'b1000`.
- Both ports target addr 0 (ALU 45, mem 99) three times back-to-back → grants strictly alternate, and the final `dataIn` matches the last granted port.
- Continuous ALU-only stream of 4 writes → `aluReady` stays 1 and `regWrite` is high for 4 consecutive cycles.
- Reset asserted while both holding registers are full → `busy` drops immediately and the held data is never written.
- With `WRARB_CONFLICT_CNT_EN`: 300 contended cycles → `conflictCount = 255`.
